// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and sizing helpers for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    // Bit counter needs at least one bit even when WIDTH is 1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder cell
module fulladder (
    output logic Sum,
    output logic Cout,
    input  logic A,
    input  logic B,
    input  logic Cin
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one bit pair per clock through a fulladder cell
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        state;
    sa_state_t        state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_shift;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             load;
    logic             last;

    fulladder u_fa (
        .Sum  (fa_sum),
        .Cout (fa_cout),
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (carry)
    );

    assign last = (cnt == LAST_BIT);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // New sum bits enter at the MSB so bit 0 lands at s_sh[0] after WIDTH shifts.
    always_comb begin
        s_shift            = s_sh >> 1;
        s_shift[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= s_shift;
            carry <= fa_cout;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Result only moves on the final bit, so the previous answer stays visible while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (state == RUN && last) begin
            sum  <= s_shift;
            cout <= fa_cout;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder against an arithmetic reference
module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        int total;
        total = int'(x) + int'(y) + int'(c);
        return total[W:0];
    endfunction

    // One isolated operation; optionally pokes start with other operands while busy.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input bit poke);
        logic [W:0] e;
        logic [W:0] held;
        int         n;
        int         busy_n;
        bit         stable;
        e = ref_add(x, y, c);
        @(negedge clk);
        start = 1'b1; a = x; b = y; cin = c;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        held = {cout, sum};
        n = 0; busy_n = 0; stable = 1'b1;
        while (!done && n < 4 * W) begin
            if (busy) busy_n++;
            if ({cout, sum} !== held) stable = 1'b0;
            if (poke && n == 2) begin
                start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
            end
            if (poke && n == 5) start = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, W);
        chk({tag, "_busy_cycles"}, busy_n, W);
        chk({tag, "_result"}, {cout, sum}, e);
        chk({tag, "_stable_while_busy"}, stable, 1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        logic [W:0]   e;
        logic [W:0]   r1;
        logic [W:0]   r2;
        int           t;
        int           t1;
        int           t2;
        int           ndone;
        int           n;
        int           gap;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;

        // Directed operand patterns
        run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0);
        run_op("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op("a5_5a_c", 8'hA5, 8'h5A, 1'b1, 1'b0);
        run_op("3c_42", 8'h3C, 8'h42, 1'b0, 1'b0);

        // start during RUN must be ignored
        run_op("ignore_start", 8'h0F, 8'h01, 1'b0, 1'b1);

        // start held high: back-to-back results WIDTH+1 cycles apart
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        a = 8'h80; b = 8'h80;
        t = 1; ndone = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0;
        while (ndone < 2 && t < 60) begin
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = t; r1 = {cout, sum};
                end else begin
                    t2 = t; r2 = {cout, sum}; start = 1'b0;
                end
            end
            if (ndone < 2) begin
                @(negedge clk);
                t++;
            end
        end
        chk("b2b_count", ndone, 2);
        chk("b2b_first_latency", t1, W + 1);
        chk("b2b_spacing", t2 - t1, W + 1);
        chk("b2b_res1", r1, ref_add(8'h01, 8'h01, 1'b0));
        chk("b2b_res2", r2, ref_add(8'h80, 8'h80, 1'b0));
        @(negedge clk);
        chk("b2b_back_idle", {busy, done}, 0);

        // Asynchronous reset in the middle of a run
        run_op("pre_rst", 8'h33, 8'h44, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        run_op("post_rst", 8'h12, 8'h34, 1'b1, 1'b0);

        // Randomized operations with random gaps, including back-to-back starts
        for (int i = 0; i < 1000; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            e = ref_add(x, y, c);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                start = 1'b0;
                repeat (gap) begin
                    @(negedge clk);
                    chk("rnd_gap_no_done", done, 0);
                end
            end
            start = 1'b1; a = x; b = y; cin = c;
            @(negedge clk);
            start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            chk("rnd_accept_busy", busy, 1);
            chk("rnd_no_double_done", done, 0);
            n = 0;
            while (!done && n < 4 * W) begin
                @(negedge clk);
                n++;
            end
            chk("rnd_latency", n, W);
            chk("rnd_result", {cout, sum}, e);
        end

        start = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
